// File: rtl/systolic_array.sv
// Output-stationary DIM x DIM signed MAC array fed by skewed A/B delay fifos.
// Operands hop one PE per enabled cycle; each PE keeps its own C accumulator.
module systolic_array #(
    parameter int DIM     = 8,
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       clr,
    input  logic [DIM*BITS_AB-1:0]     A_in,
    input  logic [DIM*BITS_AB-1:0]     B_in,
    input  logic [$clog2(DIM)-1:0]     Crow,
    output logic [DIM*BITS_C-1:0]      C_out,
    output logic                       done
);

    localparam int             CW   = $clog2(3*DIM-1);
    localparam logic [CW-1:0]  LAST = CW'(3*DIM-2);

    logic signed [BITS_AB-1:0]   a_q    [DIM][DIM];
    logic signed [BITS_AB-1:0]   b_q    [DIM][DIM];
    logic signed [BITS_C-1:0]    acc_q  [DIM][DIM];
    logic signed [BITS_AB-1:0]   a_in_s [DIM][DIM];
    logic signed [BITS_AB-1:0]   b_in_s [DIM][DIM];
    logic signed [2*BITS_AB-1:0] prod_s [DIM][DIM];
    logic signed [BITS_C-1:0]    acc_d  [DIM][DIM];
    logic        [CW-1:0]        cnt_q;
    logic        [CW-1:0]        cnt_d;
    logic                        done_q;

    // Edge PEs read the fifo lanes; interior PEs read their left/upper neighbour.
    for (genvar gr = 0; gr < DIM; gr++) begin : g_row
        for (genvar gc = 0; gc < DIM; gc++) begin : g_col
            if (gc == 0) begin : g_a_edge
                assign a_in_s[gr][gc] = A_in[gr*BITS_AB +: BITS_AB];
            end else begin : g_a_int
                assign a_in_s[gr][gc] = a_q[gr][gc-1];
            end
            if (gr == 0) begin : g_b_edge
                assign b_in_s[gr][gc] = B_in[gc*BITS_AB +: BITS_AB];
            end else begin : g_b_int
                assign b_in_s[gr][gc] = b_q[gr-1][gc];
            end
            assign prod_s[gr][gc] = a_in_s[gr][gc] * b_in_s[gr][gc];
            // Signed size cast sign-extends; the add wraps modulo 2^BITS_C.
            assign acc_d[gr][gc]  = acc_q[gr][gc] + BITS_C'(prod_s[gr][gc]);
        end
    end

    // Enabled-cycle counter next state, saturating at the completion count.
    always_comb begin
        if (cnt_q == LAST) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Array state: reset/clear beats enable, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    a_q[r][c]   <= {BITS_AB{1'b0}};
                    b_q[r][c]   <= {BITS_AB{1'b0}};
                    acc_q[r][c] <= {BITS_C{1'b0}};
                end
            end
            cnt_q  <= {CW{1'b0}};
            done_q <= 1'b0;
        end else if (en) begin
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    a_q[r][c]   <= a_in_s[r][c];
                    b_q[r][c]   <= b_in_s[r][c];
                    acc_q[r][c] <= acc_d[r][c];
                end
            end
            cnt_q  <= cnt_d;
            done_q <= (cnt_d == LAST);
        end
    end

    // Row readback mux, combinational on Crow.
    always_comb begin
        C_out = {(DIM*BITS_C){1'b0}};
        for (int c = 0; c < DIM; c++) begin
            C_out[c*BITS_C +: BITS_C] = acc_q[Crow][c];
        end
    end

    assign done = done_q;

endmodule

// File: tb/tb_systolic_array.sv
// Randomized scoreboard bench for systolic_array: jobs push C = A x B (mod 2^16),
// a negedge monitor checks done timing and sweeps every C row when results appear.
module tb_systolic_array;

    localparam int D   = 8;
    localparam int BA  = 8;
    localparam int BC  = 16;
    localparam int NEN = 3*D-2;

    typedef logic [D*D*BC-1:0] cmat_t;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            en    = 1'b0;
    logic            clr   = 1'b0;
    logic [D*BA-1:0] A_in  = '0;
    logic [D*BA-1:0] B_in  = '0;
    logic [2:0]      Crow  = 3'd0;
    logic [D*BC-1:0] C_out;
    logic            done;

    logic signed [BA-1:0] am [D][D];
    logic signed [BA-1:0] bm [D][D];
    cmat_t exp_q[$];
    cmat_t last_exp;
    int    tests = 0;
    int    fails = 0;
    int    en_cnt = 0;
    bit    checking = 1'b0;
    bit    recheck = 1'b0;
    logic  done_prev = 1'b0;

    systolic_array #(.DIM(D), .BITS_AB(BA), .BITS_C(BC)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .A_in(A_in), .B_in(B_in), .Crow(Crow), .C_out(C_out), .done(done)
    );

    always #10 clk = ~clk;

    // Bench-side count of enabled edges since the last clear or reset.
    always @(posedge clk) begin
        if (!rst_n || clr) en_cnt <= 0;
        else if (en)       en_cnt <= en_cnt + 1;
    end

    // Reference result: plain matrix product truncated to BC bits.
    function automatic cmat_t model();
        cmat_t e;
        int    sum;
        e = '0;
        for (int r = 0; r < D; r++) begin
            for (int c = 0; c < D; c++) begin
                sum = 0;
                for (int k = 0; k < D; k++) sum += int'(am[r][k]) * int'(bm[k][c]);
                e[(r*D+c)*BC +: BC] = BC'(sum);
            end
        end
        return e;
    endfunction

    task automatic sweep();
        cmat_t e;
        if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL scoreboard_empty: results presented with no expectation queued");
        end else begin
            e = exp_q.pop_front();
            for (int r = 0; r < D; r++) begin
                Crow = 3'(r);
                #1;
                tests++;
                if (C_out !== e[r*D*BC +: D*BC]) begin
                    fails++;
                    $display("FAIL c_row%0d: got %h expected %h", r, C_out, e[r*D*BC +: D*BC]);
                end
            end
        end
    endtask

    // Monitor: done must track the enabled-cycle count; read back C when it is presented.
    always @(negedge clk) begin
        if (checking) begin
            tests++;
            if (done !== (en_cnt >= NEN)) begin
                fails++;
                $display("FAIL done_timing: en_cnt=%0d got %b expected %b", en_cnt, done, (en_cnt >= NEN));
            end
            if ((done === 1'b1 && done_prev !== 1'b1) || recheck) sweep();
        end
        done_prev = done;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_lanes(input int t);
        int k;
        for (int r = 0; r < D; r++) begin
            k = t - r;
            if (k >= 0 && k < D) A_in[r*BA +: BA] = am[r][k];
            else                 A_in[r*BA +: BA] = '0;
        end
        for (int c = 0; c < D; c++) begin
            k = t - c;
            if (k >= 0 && k < D) B_in[c*BA +: BA] = bm[k][c];
            else                 B_in[c*BA +: BA] = '0;
        end
    endtask

    task automatic run_job(input bit lead_clr, input bit push, input int abort_at, input int nstall);
        int    stall_at;
        cmat_t e;
        stall_at = $urandom_range(3, NEN-4);
        e = model();
        if (lead_clr) begin
            clr = 1'b1; en = 1'b0; step(); clr = 1'b0;
        end
        if (push) begin
            exp_q.push_back(e);
            last_exp = e;
        end
        for (int t = 0; t < NEN; t++) begin
            if (t == stall_at) begin
                repeat (nstall) begin
                    en = 1'b0; A_in = {$urandom, $urandom}; B_in = {$urandom, $urandom};
                    step();
                end
            end
            drive_lanes(t);
            en = 1'b1;
            if (t == abort_at) begin
                clr = 1'b1; step(); clr = 1'b0; en = 1'b0; A_in = '0; B_in = '0;
                return;
            end
            step();
        end
        en = 1'b0; A_in = '0; B_in = '0;
        repeat (3) step();
    endtask

    task automatic do_recheck(input cmat_t e);
        exp_q.push_back(e);
        recheck = 1'b1; step(); recheck = 1'b0; step();
    endtask

    task automatic set_rand();
        for (int r = 0; r < D; r++)
            for (int c = 0; c < D; c++) begin
                am[r][c] = BA'($urandom);
                bm[r][c] = BA'($urandom);
            end
    endtask

    task automatic set_fill(input int av, input int bv);
        for (int r = 0; r < D; r++)
            for (int c = 0; c < D; c++) begin
                am[r][c] = BA'(av);
                bm[r][c] = BA'(bv);
            end
    endtask

    task automatic set_ident(input bit b_is_ident);
        for (int r = 0; r < D; r++)
            for (int c = 0; c < D; c++) begin
                am[r][c] = (r == c) ? BA'(1) : BA'(0);
                bm[r][c] = b_is_ident ? ((r == c) ? BA'(1) : BA'(0)) : BA'(r*D + c);
            end
    endtask

    initial begin
        // Reset with enable and garbage operands active.
        rst_n = 1'b0; en = 1'b1;
        A_in = {$urandom, $urandom}; B_in = {$urandom, $urandom};
        step();
        A_in = {$urandom, $urandom}; B_in = {$urandom, $urandom};
        step();
        rst_n = 1'b1; en = 1'b0; A_in = '0; B_in = '0;
        checking = 1'b1;
        do_recheck('0);

        set_ident(1'b0);
        run_job(1'b1, 1'b1, -1, 0);
        en = 1'b1;
        repeat (5) step();
        en = 1'b0;
        do_recheck(last_exp);

        run_job(1'b1, 1'b1, -1, 5);

        set_fill(-128, -128);
        run_job(1'b1, 1'b1, -1, 0);
        set_fill(-128, 127);
        run_job(1'b1, 1'b1, -1, 0);

        set_rand();
        run_job(1'b1, 1'b0, 10, 0);
        set_ident(1'b1);
        run_job(1'b0, 1'b1, -1, 0);

        repeat (4) begin
            set_rand();
            run_job(1'b1, 1'b1, -1, $urandom_range(0, 4));
        end

        repeat (3) step();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL pending_results: got %0d outstanding expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/systolic_array.md
# systolic_array

Output-stationary DIM×DIM signed multiply-accumulate array. It sits directly downstream of the A and B delay fifos: each A fifo's q drives one array row and each B fifo's q drives one array column. The fifos shift on the same en as the array, and their depths provide the diagonal skew. The array computes C = A×B into per-PE accumulators, counts enabled cycles, flags completion, and exposes one C row at a time for CSR readback.

## Interface
- DIM, 8, array dimension (rows = columns = fifo count per operand); ≥2
- BITS_AB, 8, signed element width of A and B
- BITS_C, 16, signed accumulator width; must be ≥2*BITS_AB
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  advance array one step (same en that shifts the fifos)
- clr  in  1  synchronous clear of accumulators, operand pipeline and cycle counter
- A_in  in  DIM*BITS_AB  row operands; lane r = bits [r*BITS_AB +: BITS_AB], from A fifo r q
- B_in  in  DIM*BITS_AB  column operands; lane c = bits [c*BITS_AB +: BITS_AB], from B fifo c q
- Crow  in  $clog2(DIM)  row select for readback
- C_out  out  DIM*BITS_C  accumulators of row Crow; lane c = C[Crow][c]
- done  out  1  high once 3*DIM-2 enabled cycles have elapsed since last clr/reset

## Operation
- Each PE(r,c) holds registers a_reg, b_reg (BITS_AB) and acc (BITS_C).
- PE(r,0) takes its a input from A_in lane r; PE(r,c>0) takes a_reg of PE(r,c-1).
- PE(0,c) takes its b input from B_in lane c; PE(r>0,c) takes b_reg of PE(r-1,c).
- On a clock edge with en=1, every PE latches its a input into a_reg and its b input into b_reg.
- On the same edge, every PE updates acc ← acc + sext(a_in × b_in).
  - The product is a signed full-width 2*BITS_AB result, sign-extended to BITS_C.
  - The sum wraps modulo 2^BITS_C. There is no saturation and no overflow flag.
- On an edge with en=0, all state holds (stall). The fifos stall in lockstep.
- Cycle counter: ceil(log2(3*DIM-1)) bits.
  - Increments on each edge with en=1.
  - Saturates at 3*DIM-2.
  - done = (counter == 3*DIM-2), a registered compare.
- Priority per edge: rst_n=0, then clr=1, then en=1, then hold.
  - rst_n=0 or clr=1 zeroes all a_reg, b_reg, acc and the counter, regardless of en.
  - A clr asserted mid-computation discards the partial result. The next en cycle starts a fresh accumulation.
- C_out is a combinational mux of the registered acc row selected by Crow. Changing Crow changes C_out the same cycle.
- Input skew contract (fifo side): element A[r][k] is presented on lane r at en-cycle r+k. Element B[k][c] is presented on lane c at en-cycle k+c. Zeros are presented outside those windows.

## Timing
- Reset values: C_out = 0 for any Crow; done = 0.
- An A/B pair presented at PE inputs on en-cycle t contributes to acc on that edge. The updated acc is visible on C_out after the edge.
- Operand hop latency is 1 en-cycle per PE.
  - A[r][k] meets B[k][c] at PE(r,c) on en-cycle r+c+k.
- The last contribution is on en-cycle 3*DIM-3 (0-based). After 3*DIM-2 enabled edges, all acc are final and done=1.
- done rises on the edge of the (3*DIM-2)th en-cycle. It remains high while idle or on further en until clr/reset.
- Additional en cycles after done with zero operands leave acc unchanged. Non-zero operands keep accumulating; this is the caller's responsibility.
- clr and en asserted on the same edge: clr wins, and counter = 0 after the edge.

## Test plan
- Reset: hold rst_n=0 two cycles with en=1 and random inputs → C_out=0 for every Crow 0..7, done=0.
- Identity: A=I, B[k][c]=k*8+c, skewed feed, DIM=8 → done after exactly 22 en-cycles, and C_out(row r) = B row r.
- Signed/wrap: A all -128, B all -128 → each product 16384, summed ×8 = 131072 mod 2^16 → every acc = 0. Repeat with B all 127 → every acc = -130048 mod 2^16 = 0x0400 (1024).
- Stall: the identity case with en deasserted for 5 random cycles in the middle → identical final C, done after 22 en-cycles (27 clocks).
- Mid-run clr: assert clr at en-cycle 10 of a run, then feed a fresh skewed A=I, B=I → C = I, done after 22 en-cycles from clr. clr+en on the same edge → counter 0.
- Saturation/readback: after done, 5 extra en-cycles with zero inputs → C unchanged and done=1. Sweep Crow 0..7 → each row correct the same cycle.
